// File: rtl/hvsync_decoder.sv
// Receive side of a VGA-style sync interface: recovers beam position from hsync/vsync,
// measures line period and lines per frame, and qualifies display_on with a timing lock.
module hvsync_decoder #(
    parameter int H_DISPLAY   = 640,
    parameter int H_BACK      = 48,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int V_DISPLAY   = 480,
    parameter int V_TOP       = 33,
    parameter int V_BOTTOM    = 10,
    parameter int V_SYNC      = 2,
    parameter int SYNC_DELAY  = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic signed [15:0] hpos,
    output logic signed [15:0] vpos,
    output logic               display_on,
    output logic               locked,
    output logic               frame_start,
    output logic [15:0]        line_period,
    output logic [15:0]        frame_lines,
    output logic               sig_lost
);

    localparam int H_TOTAL = H_DISPLAY + H_BACK + H_FRONT + H_SYNC;
    localparam int V_TOTAL = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC;

    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_LOAD     = 16'(H_DISPLAY + H_FRONT + SYNC_DELAY);
    localparam logic [15:0] V_LOAD     = 16'(V_DISPLAY + V_BOTTOM);
    localparam logic [15:0] H_PERIOD   = 16'(H_TOTAL);
    localparam logic [15:0] V_LINES    = 16'(V_TOTAL);
    localparam logic [15:0] LOST_LIMIT = 16'(2 * H_TOTAL);
    localparam logic [15:0] H_VIS      = 16'(H_DISPLAY);
    localparam logic [15:0] V_VIS      = 16'(V_DISPLAY);
    localparam logic [7:0]  GOOD_NEED  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_TRACKING,
        ST_LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic        hs_d_q, hs_d_d;
    logic        vs_d_q, vs_d_d;
    logic [15:0] hpos_q, hpos_d;
    logic [15:0] vpos_q, vpos_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [15:0] lcnt_q, lcnt_d;
    logic [15:0] line_period_q, line_period_d;
    logic [15:0] frame_lines_q, frame_lines_d;
    logic        line_bad_q, line_bad_d;
    logic        frame_start_q, frame_start_d;
    logic [7:0]  gcnt_q, gcnt_d;

    logic        hrise;
    logic        vrise;
    logic        bad_line;
    logic [15:0] lines_now;
    logic        frame_ok;
    logic        lost;
    logic [7:0]  gcnt_inc;

    assign hrise     = hsync_in & ~hs_d_q;
    assign vrise     = vsync_in & ~vs_d_q;
    assign bad_line  = hrise && (pcnt_q != H_PERIOD);
    // A line ending on the very edge vsync rises still belongs to the frame being closed.
    assign lines_now = lcnt_q + {15'd0, hrise};
    assign frame_ok  = !(line_bad_q || bad_line) && (lines_now == V_LINES);
    assign lost      = pcnt_q > LOST_LIMIT;
    assign gcnt_inc  = gcnt_q + 8'd1;

    // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        hs_d_d        = hsync_in;
        vs_d_d        = vsync_in;
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        pcnt_d        = pcnt_q;
        lcnt_d        = lcnt_q;
        line_period_d = line_period_q;
        frame_lines_d = frame_lines_q;
        line_bad_d    = line_bad_q;
        frame_start_d = vrise;
        state_d       = state_q;
        gcnt_d        = gcnt_q;

        if (hrise) begin
            hpos_d = H_LOAD;
        end else if (hpos_q == H_LAST) begin
            hpos_d = 16'd0;
        end else begin
            hpos_d = hpos_q + 16'd1;
        end

        if (vrise) begin
            vpos_d = V_LOAD;
        end else if (!hrise && (hpos_q == H_LAST)) begin
            vpos_d = (vpos_q == V_LAST) ? 16'd0 : vpos_q + 16'd1;
        end

        if (hrise) begin
            pcnt_d        = 16'd1;
            line_period_d = pcnt_q;
        end else if (pcnt_q != 16'hFFFF) begin
            pcnt_d = pcnt_q + 16'd1;
        end

        if (vrise) begin
            frame_lines_d = lines_now;
            lcnt_d        = {15'd0, hrise};
            line_bad_d    = 1'b0;
        end else begin
            lcnt_d        = lines_now;
            line_bad_d    = line_bad_q || bad_line;
        end

        unique case (state_q)
            ST_UNLOCKED: begin
                if (vrise) begin
                    state_d = ST_TRACKING;
                    gcnt_d  = 8'd0;
                end
            end
            ST_TRACKING: begin
                if (vrise) begin
                    if (frame_ok) begin
                        gcnt_d = gcnt_inc;
                        if (gcnt_inc >= GOOD_NEED) state_d = ST_LOCKED;
                    end else begin
                        gcnt_d = 8'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (bad_line || (vrise && !frame_ok)) begin
                    state_d = ST_UNLOCKED;
                    gcnt_d  = 8'd0;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                gcnt_d  = 8'd0;
            end
        endcase

        // Loss of hsync overrides everything, including a vsync rise on the same edge.
        if (lost) begin
            state_d = ST_UNLOCKED;
            gcnt_d  = 8'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_UNLOCKED;
            hs_d_q        <= 1'b0;
            vs_d_q        <= 1'b0;
            hpos_q        <= 16'd0;
            vpos_q        <= 16'd0;
            pcnt_q        <= 16'd0;
            lcnt_q        <= 16'd0;
            line_period_q <= 16'd0;
            frame_lines_q <= 16'd0;
            line_bad_q    <= 1'b0;
            frame_start_q <= 1'b0;
            gcnt_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            hs_d_q        <= hs_d_d;
            vs_d_q        <= vs_d_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            pcnt_q        <= pcnt_d;
            lcnt_q        <= lcnt_d;
            line_period_q <= line_period_d;
            frame_lines_q <= frame_lines_d;
            line_bad_q    <= line_bad_d;
            frame_start_q <= frame_start_d;
            gcnt_q        <= gcnt_d;
        end
    end

    assign hpos        = signed'(hpos_q);
    assign vpos        = signed'(vpos_q);
    assign locked      = (state_q == ST_LOCKED);
    assign display_on  = locked && (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign frame_start = frame_start_q;
    assign line_period = line_period_q;
    assign frame_lines = frame_lines_q;
    assign sig_lost    = lost;

endmodule

// File: tb/tb_hvsync_decoder.sv
// Bench for hvsync_decoder: a registered sync source with random phase and line jitter,
// a behavioural reference compared every cycle, and directed lock/loss/reset scenarios.
module tb_hvsync_decoder;

    localparam int H_DISPLAY = 16;
    localparam int H_BACK    = 6;
    localparam int H_FRONT   = 4;
    localparam int H_SYNC    = 6;
    localparam int V_DISPLAY = 12;
    localparam int V_TOP     = 3;
    localparam int V_BOTTOM  = 2;
    localparam int V_SYNC    = 2;
    localparam int LOCK_N    = 2;

    localparam int H_TOTAL = H_DISPLAY + H_BACK + H_FRONT + H_SYNC;   // 32
    localparam int V_TOTAL = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC;   // 19
    localparam int HSS     = H_DISPLAY + H_FRONT;                     // 20
    localparam int VSS     = V_DISPLAY + V_BOTTOM;                    // 14
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic               clk;
    logic               reset;
    logic               hsync_in;
    logic               vsync_in;
    logic signed [15:0] hpos;
    logic signed [15:0] vpos;
    logic               display_on;
    logic               locked;
    logic               frame_start;
    logic [15:0]        line_period;
    logic [15:0]        frame_lines;
    logic               sig_lost;

    hvsync_decoder #(
        .H_DISPLAY(H_DISPLAY), .H_BACK(H_BACK), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
        .V_DISPLAY(V_DISPLAY), .V_TOP(V_TOP), .V_BOTTOM(V_BOTTOM), .V_SYNC(V_SYNC),
        .SYNC_DELAY(2), .LOCK_FRAMES(LOCK_N)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hpos(hpos), .vpos(vpos), .display_on(display_on), .locked(locked),
        .frame_start(frame_start), .line_period(line_period), .frame_lines(frame_lines),
        .sig_lost(sig_lost)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Sync source: outputs are registered from the previous beam position, like a generator.
    int src_h, src_v, src_len;
    int src_vtot     = V_TOTAL;
    bit hold_low     = 0;
    bit jitter_en    = 0;
    int stretch_tok  = 0;
    int stretch_done = 0;

    initial begin
        hsync_in = 0;
        vsync_in = 0;
        src_h    = $urandom_range(H_TOTAL - 1);
        src_v    = $urandom_range(VSS - 2);
        src_len  = H_TOTAL;
        forever begin
            @(posedge clk);
            #1;
            hsync_in = !hold_low && (src_h >= HSS) && (src_h < HSS + H_SYNC);
            vsync_in = (src_v >= VSS) && (src_v < VSS + V_SYNC);
            src_h++;
            if (src_h >= src_len) begin
                src_h   = 0;
                src_len = H_TOTAL;
                if (stretch_tok != stretch_done) begin
                    src_len = H_TOTAL + 1;
                    stretch_done++;
                end else if (jitter_en && $urandom_range(15) == 0) begin
                    src_len = ($urandom_range(1) == 0) ? H_TOTAL - 1 : H_TOTAL + 1;
                end
                src_v++;
                if (src_v >= src_vtot) src_v = 0;
            end
        end
    end

    // Reference model: event rules on plain integers; locking tracked as a run of good frames.
    int cyc = 0, last_hr_cyc = 0;
    int m_hs, m_vs, m_hpos, m_vpos, m_pcnt, m_lcnt, m_lp, m_fl, m_fs;
    bit m_bad, m_armed, m_locked;
    int m_run;

    always @(posedge clk) begin
        bit hr, vr, bad_h, ok, lost, wrapped;
        int lines;
        cyc++;
        if (reset) begin
            m_hs = 0; m_vs = 0; m_hpos = 0; m_vpos = 0; m_pcnt = 0; m_lcnt = 0;
            m_lp = 0; m_fl = 0; m_fs = 0; m_bad = 0; m_armed = 0; m_locked = 0; m_run = 0;
        end else begin
            hr      = hsync_in && !m_hs;
            vr      = vsync_in && !m_vs;
            bad_h   = hr && (m_pcnt != H_TOTAL);
            lines   = m_lcnt + int'(hr);
            ok      = !(m_bad || bad_h) && (lines == V_TOTAL);
            lost    = m_pcnt > 2 * H_TOTAL;
            wrapped = !hr && (m_hpos == H_TOTAL - 1);

            if (lost || (m_locked && (bad_h || (vr && !ok)))) begin
                m_armed = 0; m_run = 0; m_locked = 0;
            end else if (vr && !m_locked) begin
                if (!m_armed) begin
                    m_armed = 1; m_run = 0;
                end else if (ok) begin
                    m_run++;
                    if (m_run >= LOCK_N) m_locked = 1;
                end else begin
                    m_run = 0;
                end
            end

            if (hr) begin
                m_lp = m_pcnt; m_pcnt = 1; last_hr_cyc = cyc;
            end else if (m_pcnt < 65535) begin
                m_pcnt++;
            end
            if (vr) begin
                m_fl = lines; m_lcnt = int'(hr); m_bad = 0;
            end else begin
                m_lcnt = lines; m_bad = m_bad || bad_h;
            end
            if (vr)           m_vpos = VSS;
            else if (wrapped) m_vpos = (m_vpos + 1) % V_TOTAL;
            m_hpos = hr ? HSS + 2 : (m_hpos + 1) % H_TOTAL;
            m_fs   = int'(vr);
            m_hs   = int'(hsync_in);
            m_vs   = int'(vsync_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hpos", int'(hpos), m_hpos);
            check("vpos", int'(vpos), m_vpos);
            check("locked", int'(locked), int'(m_locked));
            check("display_on", int'(display_on),
                  int'(m_locked && m_hpos < H_DISPLAY && m_vpos < V_DISPLAY));
            check("frame_start", int'(frame_start), m_fs);
            check("line_period", int'(line_period), m_lp);
            check("frame_lines", int'(frame_lines), m_fl);
            check("sig_lost", int'(sig_lost), int'(m_pcnt > 2 * H_TOTAL));
        end
    end

    task automatic lock_seq(input string tag);
        int  nfs = 0;
        bit  got = 0;
        for (int i = 0; i < 6 * FRAME && !got; i++) begin
            @(negedge clk);
            if (frame_start) nfs++;
            if (locked) got = 1;
        end
        check({tag, "_locked"}, int'(locked), 1);
        check({tag, "_vrises"}, nfs, 3);
        check({tag, "_on_vrise"}, int'(frame_start), 1);
    endtask

    task automatic wait_lock(input string tag, input int bound);
        for (int i = 0; i < bound && !locked; i++) @(negedge clk);
        check(tag, int'(locked), 1);
    endtask

    initial begin
        int seen, tv, th;
        bit hit;
        reset = 1;
        repeat (3) @(negedge clk);
        check("reset_locked", int'(locked), 0);
        check("reset_hpos", int'(hpos), 0);
        check("reset_line_period", int'(line_period), 0);
        reset  = 0;
        chk_en = 1;

        // Lock from a clean reset on the third vsync rise.
        lock_seq("lock_from_reset");
        check("lock_line_period", int'(line_period), H_TOTAL);
        check("lock_frame_lines", int'(frame_lines), V_TOTAL);

        // Locked position tracks the source beam exactly.
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            check("align_hpos", int'(hpos), src_h);
            check("align_vpos", int'(vpos), src_v);
            check("align_display_on", int'(display_on),
                  int'(src_h < H_DISPLAY && src_v < V_DISPLAY));
        end

        // One stretched line drops lock on the measuring hsync rise.
        stretch_tok++;
        hit = 0;
        for (int i = 0; i < 4 * H_TOTAL && !hit; i++) begin
            @(negedge clk);
            if (line_period != 16'(H_TOTAL)) hit = 1;
        end
        check("stretch_seen", int'(hit), 1);
        check("stretch_period", int'(line_period), H_TOTAL + 1);
        check("stretch_unlock", int'(locked), 0);
        lock_seq("relock_stretch");

        // Hsync held low: sig_lost 2*H_TOTAL clocks after the last rise, then unlock.
        hold_low = 1;
        hit = 0;
        for (int i = 0; i < 2 * H_TOTAL + 4 && !hit; i++) begin
            @(negedge clk);
            if (sig_lost) hit = 1;
        end
        check("lost_seen", int'(hit), 1);
        check("lost_delay", cyc - last_hr_cyc, 2 * H_TOTAL);
        @(negedge clk);
        check("lost_unlock", int'(locked), 0);
        repeat (40) @(negedge clk);
        hold_low = 0;
        hit = 0;
        for (int i = 0; i < 3 * H_TOTAL && !hit; i++) begin
            @(negedge clk);
            if (!sig_lost) hit = 1;
        end
        check("lost_cleared", int'(hit), 1);
        wait_lock("relock_lost", 8 * FRAME);

        // Short frames never lock; restoring the frame height relocks.
        src_vtot = V_TOTAL - 1;
        repeat (2 * FRAME) @(negedge clk);
        seen = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (locked) seen++;
        end
        check("short_no_lock", seen, 0);
        check("short_frame_lines", int'(frame_lines), V_TOTAL - 1);
        src_vtot = V_TOTAL;
        wait_lock("relock_short", 6 * FRAME);

        // One-cycle reset mid-frame while locked.
        tv  = 1 + $urandom_range(VSS - 3);
        th  = $urandom_range(HSS - 1);
        hit = 0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk);
            if (src_v == tv && src_h == th) hit = 1;
        end
        check("reset_point_found", int'(hit), 1);
        check("locked_before_reset", int'(locked), 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_reset_hpos", int'(hpos), 0);
        check("mid_reset_vpos", int'(vpos), 0);
        check("mid_reset_locked", int'(locked), 0);
        check("mid_reset_period", int'(line_period), 0);
        check("mid_reset_lines", int'(frame_lines), 0);
        check("mid_reset_fs", int'(frame_start), 0);
        lock_seq("relock_reset");

        // Random line-length jitter, then recovery.
        jitter_en = 1;
        repeat (8 * FRAME) @(negedge clk);
        jitter_en = 0;
        wait_lock("relock_jitter", 8 * FRAME);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
